// File: rtl/wave_capture_ctrl.sv
// Capture controller for the oscilloscope wave display: rising-crossing trigger (with timeout) into the hidden RAM half, swapped at frame start.
// Latency: every RAM write is registered and appears 1 cycle after its qualifying sample_valid strobe.
// Backpressure: none; samples arriving in WAIT_FRAME are dropped. Optional macro WAVE_CAP_DECIMATE_EN stores every 2^DECIM_LOG2-th strobe.
//
// Ports:
//   clk, reset_n (synchronous, active-low)
//   sample_valid, sample[7:0] (signed), frame_start   -- inputs
//   wr_en, wr_addr[8:0] = {half, index}, wr_data[7:0] (offset binary)
//   read_index, capturing, forced                      -- status outputs
module wave_capture_ctrl #(
    parameter int                 SAMPLES    = 256,
    parameter logic signed [7:0]  TRIG_LEVEL = 8'sd0,
    parameter int                 TIMEOUT    = 4096,
    parameter int                 DECIM_LOG2 = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    input  logic       frame_start,
    output logic       wr_en,
    output logic [8:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       read_index,
    output logic       capturing,
    output logic       forced
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_ARM,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_WAIT_FRAME
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [7:0]    index, index_nxt;
    logic          forced_pending, forced_pending_nxt;
    logic          read_index_nxt, forced_nxt;
    logic          wr_en_nxt;
    logic [8:0]    wr_addr_nxt;
    logic [7:0]    wr_data_nxt;
    logic          is_low, tmo_hit, trig_hit, decim_store;
    logic [7:0]    enc_sample;

    assign is_low     = $signed(sample) < TRIG_LEVEL;
    // The strobe that brings the count to TIMEOUT is the one seen while the count is TIMEOUT-1.
    assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
    assign trig_hit   = (state == ST_WAIT_TRIG) && !is_low;
    assign enc_sample = {~sample[7], sample[6:0]};

`ifdef WAVE_CAP_DECIMATE_EN
    localparam int DW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    logic [DW-1:0] decim_cnt;
    logic          decim_step, decim_clr;

    // The trigger sample is stored at index 0 outside this counter; the counter then
    // skips 2^DECIM_LOG2-1 strobes before each further store.
    assign decim_step  = (state == ST_CAPTURE) && sample_valid;
    assign decim_clr   = (state != ST_CAPTURE) && (state_nxt == ST_CAPTURE);
    assign decim_store = (decim_cnt == DW'((1 << DECIM_LOG2) - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || decim_clr) begin
            decim_cnt <= '0;
        end else if (decim_step) begin
            decim_cnt <= decim_store ? '0 : decim_cnt + 1'b1;
        end
    end
`else
    assign decim_store = 1'b1;
`endif

    always_comb begin
        state_nxt          = state;
        tmo_cnt_nxt        = tmo_cnt;
        index_nxt          = index;
        forced_pending_nxt = forced_pending;
        read_index_nxt     = read_index;
        forced_nxt         = forced;
        wr_en_nxt          = 1'b0;
        wr_addr_nxt        = wr_addr;
        wr_data_nxt        = wr_data;

        case (state)
            ST_ARM, ST_WAIT_TRIG: begin
                if (sample_valid) begin
                    if (tmo_cnt != TW'(TIMEOUT)) begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
                    end
                    if (trig_hit || tmo_hit) begin
                        // A real trigger wins over a simultaneous timeout.
                        state_nxt          = ST_CAPTURE;
                        forced_pending_nxt = !trig_hit;
                        wr_en_nxt          = 1'b1;
                        wr_addr_nxt        = {~read_index, 8'd0};
                        wr_data_nxt        = enc_sample;
                        index_nxt          = 8'd1;
                    end else if ((state == ST_ARM) && is_low) begin
                        state_nxt = ST_WAIT_TRIG;
                    end
                end
            end
            ST_CAPTURE: begin
                if (sample_valid && decim_store) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = {~read_index, index};
                    wr_data_nxt = enc_sample;
                    index_nxt   = index + 1'b1;
                    if (index == 8'(SAMPLES - 1)) begin
                        state_nxt = ST_WAIT_FRAME;
                    end
                end
            end
            ST_WAIT_FRAME: begin
                // wr_en high here means the final write is still being presented; a frame
                // start in that cycle is treated as coincident with the write and ignored.
                if (frame_start && !wr_en) begin
                    read_index_nxt = ~read_index;
                    forced_nxt     = forced_pending;
                    tmo_cnt_nxt    = '0;
                    state_nxt      = ST_ARM;
                end
            end
            default: state_nxt = ST_ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_ARM;
            tmo_cnt        <= '0;
            index          <= '0;
            forced_pending <= 1'b0;
            read_index     <= 1'b0;
            forced         <= 1'b0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            capturing      <= 1'b0;
        end else begin
            state          <= state_nxt;
            tmo_cnt        <= tmo_cnt_nxt;
            index          <= index_nxt;
            forced_pending <= forced_pending_nxt;
            read_index     <= read_index_nxt;
            forced         <= forced_nxt;
            wr_en          <= wr_en_nxt;
            wr_addr        <= wr_addr_nxt;
            wr_data        <= wr_data_nxt;
            capturing      <= (state_nxt == ST_CAPTURE);
        end
    end
endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Bench for wave_capture_ctrl: directed capture scenarios with random sample streams.
// Expected writes come from locating the trigger/timeout point in the whole stream.
// Writes are collected on the falling edge and compared after each capture.
module tb_wave_capture_ctrl;
    localparam int TIMEOUT = 4096;
    localparam int SAMPLES = 256;
    localparam int TRIG    = 0;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sample_valid;
    logic [7:0] sample;
    logic       frame_start;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic       read_index;
    logic       capturing;
    logic       forced;

    int total = 0;
    int bad   = 0;
    logic       ri_exp;
    logic       fp_exp;
    logic       forced_exp;
    logic [16:0] wq[$];

    wave_capture_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .frame_start  (frame_start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .read_index   (read_index),
        .capturing    (capturing),
        .forced       (forced)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic strobe(input logic [7:0] s, input int gap, input bit fs_after);
        int g;
        g = gap;
        sample_valid = 1'b1;
        sample       = s;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        if (fs_after) begin
            frame_start = 1'b1;
            @(posedge clk); #1;
            frame_start = 1'b0;
            g--;
        end
        repeat (g - 1) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
        chk({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        chk({tag, "_wr_data"},    32'(wr_data),    32'd0);
        chk({tag, "_read_index"}, 32'(read_index), 32'd0);
        chk({tag, "_capturing"},  32'(capturing),  32'd0);
        chk({tag, "_forced"},     32'(forced),     32'd0);
    endtask

    task automatic do_swap(input string tag, input bit with_valid);
        frame_start  = 1'b1;
        sample_valid = with_valid;
        sample       = 8'($urandom);
        @(posedge clk); #1;
        frame_start  = 1'b0;
        sample_valid = 1'b0;
        ri_exp     = ~ri_exp;
        forced_exp = fp_exp;
        chk({tag, "_read_index"}, 32'(read_index), 32'(ri_exp));
        chk({tag, "_forced"},     32'(forced),     32'(forced_exp));
        repeat (2) @(posedge clk); #1;
        chk({tag, "_no_write"}, 32'(wq.size()), 32'd0);
    endtask

    // kind 0: ramp from -128, 1: constant +5, 2: random.
    // abort_at >= 0 stops after that many stored samples and applies reset.
    task automatic run_capture(input string tag, input int kind, input int gap,
                               input int abort_at, input bit coincide);
        logic signed [7:0] s[$];
        int low, trig, start, n;
        s = {};
        for (int i = 0; i < TIMEOUT + SAMPLES; i++) begin
            case (kind)
                0:       s.push_back(8'(i - 128));
                1:       s.push_back(8'sd5);
                default: s.push_back(8'($urandom));
            endcase
        end
        // Arm needs a sample below the level; the trigger is the first later one at/above it.
        low  = -1;
        trig = 1 << 30;
        for (int i = 0; i < s.size(); i++) begin
            if (int'(s[i]) < TRIG) begin low = i; break; end
        end
        if (low >= 0) begin
            for (int j = low + 1; j < s.size(); j++) begin
                if (int'(s[j]) >= TRIG) begin trig = j; break; end
            end
        end
        start  = (trig <= TIMEOUT - 1) ? trig : TIMEOUT - 1;
        fp_exp = (TIMEOUT - 1) < trig;
        n      = (abort_at >= 0) ? start + abort_at : start + SAMPLES;

        wq.delete();
        for (int k = 0; k < n; k++) begin
            strobe(s[k], gap, coincide && (k == n - 1));
            if (k == start && abort_at != 0) begin
                chk({tag, "_capturing"}, 32'(capturing), 32'd1);
            end
        end

        if (abort_at >= 0) begin
            chk({tag, "_partial_writes"}, 32'(wq.size()), 32'(abort_at));
            reset_n = 1'b0;
            @(posedge clk); #1;
            reset_n = 1'b1;
            ri_exp = 1'b0; forced_exp = 1'b0;
            check_reset_outputs({tag, "_rst"});
            wq.delete();
            return;
        end

        // Strobes while waiting for the frame must be ignored.
        for (int k = 0; k < 3; k++) strobe(8'($urandom), 1, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_capturing_done"}, 32'(capturing), 32'd0);
        chk({tag, "_read_index_held"}, 32'(read_index), 32'(ri_exp));
        chk({tag, "_forced_held"}, 32'(forced), 32'(forced_exp));
        chk({tag, "_write_count"}, 32'(wq.size()), 32'(SAMPLES));
        for (int k = 0; k < SAMPLES && k < wq.size(); k++) begin
            chk({tag, "_addr"}, 32'(wq[k][16:8]), 32'({~ri_exp, 8'(k)}));
            chk({tag, "_data"}, 32'(wq[k][7:0]),  32'(8'(s[start + k]) ^ 8'h80));
        end
        wq.delete();
    endtask

    initial begin
        reset_n = 1'b0; sample_valid = 1'b0; frame_start = 1'b0; sample = 8'h00;
        ri_exp = 1'b0; fp_exp = 1'b0; forced_exp = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Ramp: triggers on 0x00, writes 0x100.. with data 0x80..
        run_capture("ramp", 0, 4, -1, 1'b0);
        chk("ramp_first_data_seen", 32'(forced), 32'd0);
        do_swap("swap1", 1'b1);

        // Random stream into the lower half; frame start coincident with final write.
        run_capture("rand_lo", 2, 2, -1, 1'b1);
        chk("coincide_read_index", 32'(read_index), 32'(ri_exp));
        do_swap("swap2", 1'b0);

        // Constant above the level: only the timeout starts this capture.
        run_capture("timeout", 1, 1, -1, 1'b0);
        do_swap("swap3", 1'b0);
        chk("timeout_forced", 32'(forced), 32'd1);

        // Random capture after a forced one clears forced on the swap.
        run_capture("rand2", 2, 1, -1, 1'b0);
        do_swap("swap4", 1'b0);

        // Reset at index 100, then a clean capture starts at index 0 in the upper half.
        run_capture("abort", 2, 2, 100, 1'b0);
        run_capture("after_rst", 2, 1, -1, 1'b0);
        do_swap("swap5", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
